// File: rtl/ttt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ttt_pkg : cell codes, board constants and FSM state encoding             |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_P1     = 2'b01;
  localparam logic [1:0] CELL_P2     = 2'b10;
  localparam logic [1:0] RESULT_DRAW = 2'b11;

  localparam int         NUM_CELLS = 9;
  localparam logic [3:0] LAST_IDX  = 4'd8;
  localparam logic [3:0] MAX_MOVES = 4'd9;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [1:0] other_player(input logic [1:0] code);
    return (code == CELL_P1) ? CELL_P2 : CELL_P1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ttt_game_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ttt_game_ctrl_if : move request handshake between player and controller  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface ttt_game_ctrl_if;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;
  logic       illegal;

  modport master (output move_valid, output move_pos, input move_ready, input illegal);
  modport slave  (input move_valid, input move_pos, output move_ready, output illegal);
endinterface
`default_nettype wire

// File: rtl/ttt_board_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ttt_board_reg : 9x2-bit board storage, one write port, occupancy lookup  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module ttt_board_reg
  import ttt_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [1:0]  wr_code,
  input  logic [3:0]  rd_idx,
  output logic        occupied,
  output logic [17:0] board
);

  logic [1:0] r_cells [NUM_CELLS];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_CELLS; i++) r_cells[i] <= CELL_EMPTY;
    end else if (wr_en && (wr_idx <= LAST_IDX)) begin
      r_cells[wr_idx] <= wr_code;
    end
  end

  // Out-of-range indices report empty; the caller rejects them separately.
  assign occupied = (rd_idx <= LAST_IDX) ? (r_cells[rd_idx] != CELL_EMPTY) : 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CELLS; gi++) begin : g_flat
      assign board[2*gi+1:2*gi] = r_cells[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ttt_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ttt_game_ctrl : tic-tac-toe turn/legality FSM; optional TTT_TIMEOUT_EN   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER   = 2'b01,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_game,
  ttt_game_ctrl_if.slave    mv,
  output logic [17:0]       board,
  output logic [1:0]        turn,
  input  logic              win_valid,
  input  logic [1:0]        win_who,
  output logic              game_over,
  output logic [1:0]        result,
  output logic [3:0]        move_count
`ifdef TTT_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  localparam logic [1:0] S_PLAY  = PLAY;
  localparam logic [1:0] S_CHECK = CHECK;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0] r_state;
  logic [1:0] r_turn;
  logic [1:0] r_result;
  logic [3:0] r_count;
  logic       r_illegal;

  logic w_clr;
  logic w_occupied;
  logic w_bad;
  logic w_req;
  logic w_accept;
  logic w_expire;

  assign w_clr    = reset | new_game;
  assign w_req    = (r_state == S_PLAY) && mv.move_valid;
  assign w_bad    = (mv.move_pos > LAST_IDX) || w_occupied;
  assign w_accept = w_req && !w_bad;

  ttt_board_reg u_board (
    .clk      (clk),
    .clr      (w_clr),
    .wr_en    (w_accept),
    .wr_idx   (mv.move_pos),
    .wr_code  (r_turn),
    .rd_idx   (mv.move_pos),
    .occupied (w_occupied),
    .board    (board)
  );

`ifdef TTT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_idle_cnt;
  logic            r_timeout;

  assign w_expire = (r_state == S_PLAY) && !w_accept &&
                    (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if ((r_state != S_PLAY) || w_accept || w_expire) r_idle_cnt <= '0;
      else                                             r_idle_cnt <= TO_W'(r_idle_cnt + 1'b1);
    end
  end

  assign timeout = r_timeout;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = |TIMEOUT_CYCLES;
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state   <= S_PLAY;
      r_turn    <= FIRST_PLAYER;
      r_result  <= CELL_EMPTY;
      r_count   <= 4'd0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_req && w_bad;
      case (r_state)
        S_PLAY: begin
          if (w_accept) begin
            r_count <= 4'(r_count + 4'd1);
            r_state <= S_CHECK;
          end else if (w_expire) begin
            r_turn <= other_player(r_turn);
          end
        end
        S_CHECK: begin
          // A winning ninth move is checked before the draw condition.
          if (win_valid) begin
            r_result <= win_who;
            r_state  <= S_DONE;
          end else if (r_count == MAX_MOVES) begin
            r_result <= RESULT_DRAW;
            r_state  <= S_DONE;
          end else begin
            r_turn  <= other_player(r_turn);
            r_state <= S_PLAY;
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_PLAY;
      endcase
    end
  end

  assign mv.move_ready = (r_state == S_PLAY);
  assign mv.illegal    = r_illegal;
  assign game_over     = (r_state == S_DONE);
  assign turn          = (r_state == S_DONE) ? CELL_EMPTY : r_turn;
  assign result        = r_result;
  assign move_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ttt_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ttt_game_ctrl : vector-table bench for ttt_game_ctrl (TTT_TIMEOUT_EN) |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_ttt_game_ctrl;

  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;

  typedef struct {
    logic        rst;
    logic        ng;
    logic        mv;
    logic [3:0]  pos;
    logic [28:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game;
  logic [17:0] board;
  logic [1:0]  turn;
  logic        win_valid;
  logic [1:0]  win_who;
  logic        game_over;
  logic [1:0]  result;
  logic [3:0]  move_count;
`ifdef TTT_TIMEOUT_EN
  logic        timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  ttt_game_ctrl_if mvif ();

  ttt_game_ctrl #(.FIRST_PLAYER(2'b01), .TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .mv         (mvif.slave),
    .board      (board),
    .turn       (turn),
    .win_valid  (win_valid),
    .win_who    (win_who),
    .game_over  (game_over),
    .result     (result),
    .move_count (move_count)
`ifdef TTT_TIMEOUT_EN
    ,
    .timeout    (timeout)
`endif
  );

  always #5 clk = ~clk;

  // Reference detector bank: any complete line of one player's code.
  function automatic logic [2:0] detect(input logic [17:0] b);
    int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    logic [1:0] a;
    for (int k = 0; k < 8; k++) begin
      a = b[2*ln[k][0] +: 2];
      if (a != 2'b00 && a == b[2*ln[k][1] +: 2] && a == b[2*ln[k][2] +: 2])
        return {1'b1, a};
    end
    return 3'b000;
  endfunction

  always_comb {win_valid, win_who} = detect(board);

  function automatic logic [17:0] cb(input int i, input logic [1:0] code);
    return 18'(code) << (2 * i);
  endfunction

  function automatic logic [28:0] pk(input logic [17:0] b, input logic [1:0] t,
                                     input logic il, input logic rdy, input logic ov,
                                     input logic [1:0] res, input logic [3:0] cnt);
    return {b, t, il, rdy, ov, res, cnt};
  endfunction

  function automatic void add(input logic rst, input logic ng, input logic mv,
                              input logic [3:0] pos, input logic [28:0] exp);
    vec_t v;
    v.rst = rst; v.ng = ng; v.mv = mv; v.pos = pos; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic ng, input logic mv, input logic [3:0] pos);
    reset = rst; new_game = ng; mvif.move_valid = mv; mvif.move_pos = pos;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [17:0] b;
    logic [1:0]  code;
    int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int win9_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 8, 6};

    reset = 1'b1; new_game = 1'b0; mvif.move_valid = 1'b0; mvif.move_pos = 4'd0;

    // P1 wins on the 2-4-6 diagonal
    add(1, 0, 0, 0, pk(0, P1, 0, 1, 0, 0, 0));
    b = cb(4, P1);
    add(0, 0, 1, 4, pk(b, P1, 0, 0, 0, 0, 1));
    add(0, 0, 0, 0, pk(b, P2, 0, 1, 0, 0, 1));
    b |= cb(0, P2);
    add(0, 0, 1, 0, pk(b, P2, 0, 0, 0, 0, 2));
    add(0, 0, 0, 0, pk(b, P1, 0, 1, 0, 0, 2));
    b |= cb(2, P1);
    add(0, 0, 1, 2, pk(b, P1, 0, 0, 0, 0, 3));
    add(0, 0, 0, 0, pk(b, P2, 0, 1, 0, 0, 3));
    b |= cb(1, P2);
    add(0, 0, 1, 1, pk(b, P2, 0, 0, 0, 0, 4));
    add(0, 0, 0, 0, pk(b, P1, 0, 1, 0, 0, 4));
    b |= cb(6, P1);
    add(0, 0, 1, 6, pk(b, P1, 0, 0, 0, 0, 5));
    add(0, 0, 0, 0, pk(b, 2'b00, 0, 0, 1, P1, 5));
    add(0, 0, 1, 7, pk(b, 2'b00, 0, 0, 1, P1, 5));
    add(0, 1, 1, 3, pk(0, P1, 0, 1, 0, 0, 0));

    // illegal requests: occupied cell, out-of-range indices, move during CHECK
    b = cb(4, P1);
    add(0, 0, 1, 4, pk(b, P1, 0, 0, 0, 0, 1));
    add(0, 0, 0, 0, pk(b, P2, 0, 1, 0, 0, 1));
    add(0, 0, 1, 4, pk(b, P2, 1, 1, 0, 0, 1));
    add(0, 0, 1, 4, pk(b, P2, 1, 1, 0, 0, 1));
    add(0, 0, 1, 9, pk(b, P2, 1, 1, 0, 0, 1));
    add(0, 0, 1, 15, pk(b, P2, 1, 1, 0, 0, 1));
    add(0, 0, 0, 0, pk(b, P2, 0, 1, 0, 0, 1));
    b |= cb(0, P2);
    add(0, 0, 1, 0, pk(b, P2, 0, 0, 0, 0, 2));
    add(0, 0, 1, 5, pk(b, P1, 0, 1, 0, 0, 2));
    add(0, 1, 1, 1, pk(0, P1, 0, 1, 0, 0, 0));

    // full drawn game
    b = '0;
    for (int k = 0; k < 9; k++) begin
      code = (k % 2 == 0) ? P1 : P2;
      b |= cb(draw_seq[k], code);
      add(0, 0, 1, 4'(draw_seq[k]), pk(b, code, 0, 0, 0, 0, 4'(k + 1)));
      if (k < 8) add(0, 0, 0, 0, pk(b, (code == P1) ? P2 : P1, 0, 1, 0, 0, 4'(k + 1)));
      else       add(0, 0, 0, 0, pk(b, 2'b00, 0, 0, 1, 2'b11, 4'd9));
    end
    add(0, 1, 1, 4, pk(0, P1, 0, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ng, vecs[i].mv, vecs[i].pos);
      chk($sformatf("vec%0d", i),
          32'({board, turn, mvif.illegal, mvif.move_ready, game_over, result, move_count}),
          32'(vecs[i].exp));
    end

    // win completed on the ninth move must report the winner
    for (int k = 0; k < 9; k++) begin
      step(0, 0, 1, 4'(win9_seq[k]));
      step(0, 0, 0, 0);
    end
    chk("win9_result", 32'(result), 32'(P1));
    chk("win9_count", 32'(move_count), 32'd9);
    chk("win9_over", 32'({game_over, turn}), 32'b100);

`ifdef TTT_TIMEOUT_EN
    step(0, 1, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 0);
    chk("to_before", 32'({timeout, turn}), 32'({1'b0, P1}));
    step(0, 0, 0, 0);
    chk("to_pulse", 32'({timeout, turn, board}), 32'({1'b1, P2, 18'd0}));
    step(0, 0, 0, 0);
    chk("to_end", 32'({timeout, turn, move_count}), 32'({1'b0, P2, 4'd0}));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
